fetch_stage: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register feeding the decode-stage control decoder.
//  - Holds the PC and drives a multi-cycle instruction-memory handshake.
//  - Presents the fetched word to decode with a valid bit; if_op = if_instr[15:11] is the decoder's I_op.
//  - Handles decode stalls, branch/jump redirects from EX, and the halt condition reported by decode.

---
 rtl/wisc_pkg.sv | 11 +
 rtl/fetch_skid_buf.sv | 23 ++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// wisc_pkg: shared opcodes, bubble word and fetch state encoding
package wisc_pkg;
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_NOP = 5'b00001;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_FETCH = 2'd0;
  localparam fetch_state_t S_HOLD = 2'd1;
  localparam fetch_state_t S_DRAIN = 2'd2;
  localparam fetch_state_t S_HALT = 2'd3;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: single-entry {instr, pc_plus2} buffer for words returned during a decode stall
module fetch_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] instr_d,
  input  logic [DATA_W-1:0] pc_plus2_d,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] pc_plus2
);
  always_ff @(posedge clk) begin
    if (rst || clear) valid <= 1'b0;
    else if (load) begin
      valid <= 1'b1;
      instr <= instr_d;
      pc_plus2 <= pc_plus2_d;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, instruction-memory handshake and IF/ID register with stall, redirect and halt handling
module fetch_stage
  import wisc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = wisc_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_done,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              id_stall,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              halt_d,
  output logic [DATA_W-1:0] if_instr,
  output logic [4:0]        if_op,
  output logic [DATA_W-1:0] if_pc_plus2,
  output logic              if_valid,
  output logic              halted
);
  fetch_state_t state, state_n;
  logic [DATA_W-1:0] pc, pc_n, pc_plus2, instr_n, pcp2_n, skid_instr, skid_pcp2;
  logic valid_n, skid_load, skid_clr, skid_valid;
  assign pc_plus2 = pc + DATA_W'(2);
  assign imem_req = !rst && state == S_FETCH;
  assign imem_addr = pc;
  assign halted = state == S_HALT;
  assign if_op = if_instr[DATA_W-1 -: 5];
  fetch_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk(clk), .rst(rst), .load(skid_load), .clear(skid_clr),
    .instr_d(imem_rdata), .pc_plus2_d(pc_plus2),
    .valid(skid_valid), .instr(skid_instr), .pc_plus2(skid_pcp2)
  );
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = if_instr;
    pcp2_n = if_pc_plus2;
    valid_n = if_valid;
    skid_load = 1'b0;
    skid_clr = 1'b0;
    if (state == S_HALT) begin
    end else if (redirect_valid) begin
      pc_n = redirect_pc;
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
      skid_clr = 1'b1;
      state_n = ((state == S_FETCH || state == S_DRAIN) && !imem_done) ? S_DRAIN : S_FETCH;
    end else if (state == S_DRAIN) begin
      state_n = imem_done ? S_FETCH : S_DRAIN;
    end else if (halt_d) begin
      // keep the HALT word in IF/ID; wait out an in-flight access before stopping
      skid_clr = 1'b1;
      state_n = (state == S_HOLD || imem_done) ? S_HALT : state;
    end else if (state == S_HOLD) begin
      if (!id_stall) begin
        instr_n = skid_instr;
        pcp2_n = skid_pcp2;
        valid_n = skid_valid;
        skid_clr = 1'b1;
        state_n = S_FETCH;
      end
    end else if (imem_done) begin
      pc_n = pc_plus2;
      skid_load = id_stall;
      state_n = id_stall ? S_HOLD : S_FETCH;
      instr_n = id_stall ? if_instr : imem_rdata;
      pcp2_n = id_stall ? if_pc_plus2 : pc_plus2;
      valid_n = id_stall ? if_valid : 1'b1;
    end else if (!id_stall) begin
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      if_instr <= NOP_INSTR;
      if_pc_plus2 <= RESET_PC + DATA_W'(2);
      if_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if_instr <= instr_n;
      if_pc_plus2 <= pcp2_n;
      if_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a latency-configurable memory model
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req, imem_done, id_stall = 1'b0, redirect_valid = 1'b0, halt_d = 1'b0;
  logic if_valid, halted;
  logic [15:0] imem_addr, imem_rdata, redirect_pc = '0, if_instr, if_pc_plus2;
  logic [4:0] if_op;
  int n_checks = 0, n_fail = 0;
  int lat = 1, cnt = 0;
  logic busy = 1'b0, pend = 1'b0;
  logic [15:0] paddr = '0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_done(imem_done), .imem_rdata(imem_rdata), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_d(halt_d),
    .if_instr(if_instr), .if_op(if_op), .if_pc_plus2(if_pc_plus2),
    .if_valid(if_valid), .halted(halted)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == 16'h0102) ? 16'h0000 : 16'h4001 + {1'b0, a[15:1]};
  endfunction
  assign imem_done = !rst && (busy || imem_req) && cnt == lat - 1;
  assign imem_rdata = imem_req ? mem_word(imem_addr) : 16'hDEAD;
  always @(posedge clk) begin
    if (rst || imem_done) begin
      busy <= 1'b0;
      cnt <= 0;
    end else if (busy || imem_req) begin
      busy <= 1'b1;
      cnt <= cnt + 1;
    end
    pend <= imem_req && !imem_done && !rst;
    paddr <= imem_addr;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (pend && imem_req) check("addr_stable", imem_addr, paddr);
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic ifid(input string tag, input logic [15:0] i, input logic [15:0] p, input logic v);
    check({tag, "_instr"}, if_instr, i);
    check({tag, "_pc2"}, if_pc_plus2, p);
    check({tag, "_valid"}, if_valid, v);
  endtask
  initial begin
    step();
    step();
    ifid("reset", 16'h0800, 16'h0002, 1'b0);
    check("reset_req", imem_req, 0);
    check("reset_halted", halted, 0);
    rst = 1'b0;
    #1;
    check("t1_req", imem_req, 1);
    check("t1_addr", imem_addr, 16'h0000);
    step();
    ifid("t1_a", 16'h4001, 16'h0002, 1'b1);
    check("t1_op", if_op, 5'b01000);
    step();
    ifid("t1_b", 16'h4002, 16'h0004, 1'b1);
    step();
    ifid("t1_c", 16'h4003, 16'h0006, 1'b1);
    lat = 3;
    step();
    ifid("t2_bub1", 16'h0800, 16'h0006, 1'b0);
    check("t2_addr1", imem_addr, 16'h0006);
    step();
    ifid("t2_bub2", 16'h0800, 16'h0006, 1'b0);
    step();
    ifid("t2_a", 16'h4004, 16'h0008, 1'b1);
    step();
    step();
    ifid("t2_bub3", 16'h0800, 16'h0008, 1'b0);
    step();
    ifid("t2_b", 16'h4005, 16'h000A, 1'b1);
    lat = 1;
    id_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ifid("t3_hold", 16'h4005, 16'h000A, 1'b1);
      check("t3_req", imem_req, 0);
    end
    id_stall = 1'b0;
    step();
    ifid("t3_skid", 16'h4006, 16'h000C, 1'b1);
    check("t3_addr", imem_addr, 16'h000C);
    step();
    ifid("t3_next", 16'h4007, 16'h000E, 1'b1);
    lat = 3;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    step();
    redirect_valid = 1'b0;
    check("t4_drain_req", imem_req, 0);
    check("t4_drain_valid", if_valid, 0);
    step();
    check("t4_req", imem_req, 1);
    check("t4_addr", imem_addr, 16'h0100);
    check("t4_valid0", if_valid, 0);
    step();
    check("t4_valid1", if_valid, 0);
    step();
    check("t4_valid2", if_valid, 0);
    step();
    ifid("t4_word", 16'h4081, 16'h0102, 1'b1);
    lat = 1;
    step();
    ifid("t5_haltword", 16'h0000, 16'h0104, 1'b1);
    check("t5_op", if_op, 5'b00000);
    halt_d = 1'b1;
    step();
    check("t5_halted", halted, 1);
    check("t5_req", imem_req, 0);
    ifid("t5_keep", 16'h0000, 16'h0104, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0300;
    step();
    redirect_valid = 1'b0;
    check("t5_ign_halted", halted, 1);
    check("t5_ign_req", imem_req, 0);
    check("t5_ign_addr", imem_addr, 16'h0104);
    ifid("t5_ign", 16'h0000, 16'h0104, 1'b1);
    step();
    check("t5_still", halted, 1);
    rst = 1'b1;
    halt_d = 1'b0;
    step();
    rst = 1'b0;
    halt_d = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    step();
    halt_d = 1'b0;
    redirect_valid = 1'b0;
    check("t5v_halted", halted, 0);
    check("t5v_req", imem_req, 1);
    check("t5v_addr", imem_addr, 16'h0040);
    check("t5v_valid", if_valid, 0);
    step();
    ifid("t5v_word", 16'h4021, 16'h0042, 1'b1);
    check("t5v_halted2", halted, 0);
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    check("t6_addr", imem_addr, 16'hFFFE);
    step();
    ifid("t6_wrap", 16'hC000, 16'h0000, 1'b1);
    check("t6_addr_wrap", imem_addr, 16'h0000);
    lat = 3;
    step();
    rst = 1'b1;
    step();
    check("t6_rst_req", imem_req, 0);
    ifid("t6_rst", 16'h0800, 16'h0002, 1'b0);
    rst = 1'b0;
    #1;
    check("t6_rel_req", imem_req, 1);
    check("t6_rel_addr", imem_addr, 16'h0000);
    step();
    check("t6_after_valid", if_valid, 0);
    check("t6_after_addr", imem_addr, 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
